// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame constants, and the scan
// codes used by the receiver and the downstream key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  // Prefix codes; the receiver passes them through as ordinary bytes
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  // Key codes shared with the key decoder
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  // Odd parity: data plus parity bit must carry an odd number of ones
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_receiver_line_filter.sv
// Synchronizer plus glitch filter for one PS/2 line. The output changes only
// after FILT_LEN consecutive synchronized samples that disagree with it.
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer followed by the run-length filter; idle level is 1
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_filt <= 1'b1;
      cnt       <= '0;
    end else begin
      sync1 <= line_raw;
      sync2 <= sync1;
      if (sync2 == line_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        line_filt <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: filters both lines, frames 11-bit words on filtered
// PS2_CLK falling edges, checks odd parity and stop bit, and abandons stalled
// frames after TIMEOUT_CYC cycles.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] scan_code,
  output logic        FLAG,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_filt;
  logic          data_filt;
  logic          clk_filt_q;
  logic          fall;
  ps2_state_t    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .CLK       (CLK),
    .rst       (rst),
    .line_raw  (PS2_CLK),
    .line_filt (clk_filt)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
    .CLK       (CLK),
    .rst       (rst),
    .line_raw  (PS2_DATA),
    .line_filt (data_filt)
  );

  assign fall = clk_filt_q & ~clk_filt;

  // Frame FSM, timeout counter and registered one-cycle status pulses
  always_ff @(posedge CLK) begin
    if (rst) begin
      clk_filt_q <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      FLAG       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_filt_q <= clk_filt;
      FLAG       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      // A falling edge wins over a timeout expiring in the same cycle
      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_filt) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= data_filt;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_filt) begin
              frame_err <= 1'b1;
            end else if (parity_ok(shreg, par_bit)) begin
              scan_code <= {scan_code[7:0], shreg};
              FLAG      <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt >= TW'(TIMEOUT_CYC - 1)) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        shreg     <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed PS/2 frames, expected pulses
// queued by the driver and matched by an independent monitor.
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;
  // Pin fall to registered pulse: 2 sync + FILT filter + 1 register
  localparam int unsigned DLY  = FILT + 3;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DATA = 1'b1;
  logic [15:0] scan_code;
  logic        FLAG;
  logic        parity_err;
  logic        frame_err;

  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          tag;
    logic [2:0]  kind;   // {frame_err, parity_err, FLAG}
    logic [15:0] scan;
    int unsigned delay;  // cycles after the last driven PS2_CLK fall
  } exp_t;

  exp_t exp_q[$];

  ps2_receiver #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .scan_code  (scan_code),
    .FLAG       (FLAG),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_pulse(input int tag, input logic [2:0] kind,
                              input logic [15:0] scan, input int unsigned delay);
    exp_t e;
    e.tag   = tag;
    e.kind  = kind;
    e.scan  = scan;
    e.delay = delay;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge CLK);
    PS2_DATA = b;
    if (glitch) begin
      repeat (5) @(negedge CLK);
      PS2_DATA = ~b;
      repeat (3) @(negedge CLK);
      PS2_DATA = b;
      repeat (HALF - 8) @(negedge CLK);
    end else begin
      repeat (HALF) @(negedge CLK);
    end
    PS2_CLK   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(stop, glitch);
    PS2_DATA = 1'b1;
    repeat (30) @(negedge CLK);
  endtask

  // Monitor: every status pulse must match the head of the expectation queue
  exp_t        cur;
  logic        prev_pulse = 1'b0;
  logic [2:0]  kind_now;
  int unsigned lo;
  int unsigned hi;
  always @(negedge CLK) begin
    kind_now = {frame_err, parity_err, FLAG};
    if (kind_now != 3'b000) begin
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d kind=%b required no pulse after a pulse", cyc, kind_now);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d kind=%b scan=%h required none", cyc, kind_now, scan_code);
      end else begin
        cur = exp_q.pop_front();
        lo  = last_fall + cur.delay - 1;
        hi  = last_fall + cur.delay + 1;
        if (kind_now !== cur.kind || scan_code !== cur.scan || cyc < lo || cyc > hi) begin
          errors++;
          $display("FAIL pulse_%0d actual kind=%b scan=%h cyc=%0d required kind=%b scan=%h cyc=%0d..%0d",
                   cur.tag, kind_now, scan_code, cyc, cur.kind, cur.scan, lo, hi);
        end
      end
    end
    prev_pulse = (kind_now != 3'b000);
  end

  initial begin
    logic [7:0] partial;
    partial = KEY_LEFT;

    rst = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rst_scan", scan_code, 16'h0000);
    chk("rst_pulses", {13'd0, frame_err, parity_err, FLAG}, 16'h0000);
    rst = 1'b0;
    repeat (10) @(negedge CLK);
    chk("idle_scan", scan_code, 16'h0000);
    chk("idle_pulses", {13'd0, frame_err, parity_err, FLAG}, 16'h0000);

    // 0x75, good parity
    expect_pulse(1, 3'b001, 16'h0075, DLY);
    send_frame(KEY_UP, 1'b0, 1'b1, 1'b0);

    // Break prefix then 0x75
    expect_pulse(2, 3'b001, 16'h75F0, DLY);
    send_frame(CODE_BREAK, 1'b1, 1'b1, 1'b0);
    expect_pulse(3, 3'b001, 16'hF075, DLY);
    send_frame(KEY_UP, 1'b0, 1'b1, 1'b0);

    // Bad parity
    expect_pulse(4, 3'b010, 16'hF075, DLY);
    send_frame(KEY_UP, 1'b1, 1'b1, 1'b0);

    // Bad stop bit together with bad parity: only frame_err
    expect_pulse(5, 3'b100, 16'hF075, DLY);
    send_frame(KEY_RIGHT, 1'b0, 1'b0, 1'b0);

    // Start plus 5 data bits, then silence until timeout
    expect_pulse(6, 3'b100, 16'hF075, DLY + TMO);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(partial[i], 1'b0);
    repeat (TMO + 40) @(negedge CLK);
    expect_pulse(7, 3'b001, 16'h756B, DLY);
    send_frame(KEY_LEFT, 1'b0, 1'b1, 1'b0);

    // Short clock glitches while idle, then a frame with data glitches
    for (int g = 0; g < 3; g++) begin
      @(negedge CLK);
      PS2_CLK = 1'b0;
      repeat (2) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (10) @(negedge CLK);
    end
    chk("glitch_scan", scan_code, 16'h756B);
    expect_pulse(8, 3'b001, 16'h6B29, DLY);
    send_frame(KEY_SPACE, 1'b0, 1'b1, 1'b1);

    // Reset after the 4th data bit, then a prompt new frame
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(partial[i], 1'b0);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    chk("midrst_scan", scan_code, 16'h0000);
    repeat (5) @(negedge CLK);
    expect_pulse(9, 3'b001, 16'h0076, DLY);
    send_frame(KEY_ESC, 1'b0, 1'b1, 1'b0);

    repeat (50) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses actual=%0d outstanding required=0 (next tag %0d)",
               exp_q.size(), exp_q[0].tag);
    end
    chk("final_scan", scan_code, 16'h0076);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILT_LEN, 4: consecutive equal samples required before a filtered PS/2 line changes value.
REQ-002 Parameter TIMEOUT_CYC, 100000: CLK cycles without a filtered PS2_CLK falling edge before a partial frame is abandoned.
REQ-003 CLK  input  1  board clock; single clock domain; all state on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 PS2_CLK  input  1  keyboard clock; asynchronous; idles high.
REQ-006 PS2_DATA  input  1  keyboard data; asynchronous; idles high.
REQ-007 scan_code  output  16  [15:8] previous accepted byte, [7:0] latest accepted byte.
REQ-008 FLAG  output  1  one-cycle pulse, new byte in scan_code[7:0].
REQ-009 parity_err  output  1  one-cycle pulse, frame dropped because of bad parity.
REQ-010 frame_err  output  1  one-cycle pulse, frame dropped because of bad stop bit or timeout.

Function
REQ-011 Each PS/2 input SHALL pass a 2-flop synchronizer, then a filter that updates its output only after FILT_LEN identical consecutive synchronized samples.
REQ-012 A falling edge SHALL be detected when the filtered PS2_CLK goes 1->0; the filtered PS2_DATA value in that same cycle is the sampled bit.
REQ-013 Frame: start 0, 8 data bits LSB first, odd parity bit (data plus parity has an odd number of ones), stop 1; 11 falling edges in total.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sampled 0 -> DATA (bit counter cleared); sampled 1 -> stay IDLE, no pulse.
  - DATA: shift the bit into the byte register; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: return to IDLE in all cases.
REQ-015 In STOP, sampled 1 with good parity SHALL:
  - set scan_code <= {scan_code[7:0], byte};
  - pulse FLAG high for exactly one cycle, in the cycle after the stop-bit edge is detected.
REQ-016 In STOP, sampled 1 with bad parity SHALL pulse parity_err and leave scan_code and FLAG unchanged.
REQ-017 In STOP, sampled 0 SHALL pulse frame_err and leave scan_code unchanged; parity_err SHALL NOT pulse, since the stop error takes precedence.
REQ-018 Outside IDLE, a cycle counter SHALL count cycles since the last falling edge. Reaching TIMEOUT_CYC SHALL:
  - force IDLE;
  - discard the partial byte;
  - pulse frame_err once.
REQ-019 The timeout counter SHALL be held at 0 in IDLE and cleared on every falling edge; it SHALL saturate and never wrap.
REQ-020 FLAG, parity_err and frame_err SHALL be mutually exclusive and never high in two consecutive cycles.
REQ-021 Latency from the pin: a PS2_CLK fall that stays stable is detected 2+FILT_LEN cycles later (±1); FLAG follows one cycle after that.
REQ-022 Break (F0) and extended (E0) prefixes SHALL be passed through as ordinary bytes; interpreting them belongs to the downstream stage.

Reset
REQ-023 While rst is high, the block SHALL set:
  - state IDLE;
  - scan_code 16'h0000;
  - FLAG, parity_err, frame_err all 0;
  - bit counter and timeout counter 0;
  - synchronizer and filter registers 1 (the idle line level).
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no pulses. The first falling edge after release SHALL be treated as a possible start bit.

Structure
REQ-025 Shared package ps2_pkg SHALL hold:
  - the FSM state enum;
  - frame constants (DATA_BITS=8, the FRAME_BITS=11 frame size);
  - prefix codes F0 and E0;
  - key codes 75/72/6B/74/29/76, so the downstream key decoder uses the same definitions.
REQ-026 Sub-module ps2_line_filter (synchronizer plus FILT_LEN filter) SHALL be instantiated twice, once for PS2_CLK and once for PS2_DATA.

Verification (device bit period 60 us, CLK 100 MHz)
REQ-027 Send 0x75 with parity 0 -> one FLAG pulse; scan_code=16'h0075; no error pulses.
REQ-028 Send 0xF0 (parity 1), then 0x75 (parity 0) -> two FLAG pulses; final scan_code=16'hF075.
REQ-029 Send 0x75 with parity 1 -> parity_err pulses once; FLAG stays 0; scan_code unchanged.
REQ-030 Send start plus 5 data bits, then idle -> frame_err pulses once, TIMEOUT_CYC cycles after the last edge. A following 0x6B (parity 0) -> scan_code[7:0]=8'h6B with FLAG.
REQ-031 Insert 2-cycle low glitches on PS2_CLK while idle, and 3-cycle glitches on PS2_DATA mid-bit, with FILT_LEN=4 -> no extra edges; a 0x29 frame decodes correctly.
REQ-032 Assert rst for 1 cycle after the 4th data bit -> no pulses; a following 0x76 (parity 0) -> scan_code=16'h0076, FLAG once.
